// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: instruction memory with a fault-checking fetch port and an in-order response FIFO
module instr_fetch_mem #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          ADDR_W      = 32,
    parameter int          RESP_DEPTH  = 2,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [ADDR_W-1:0]              req_addr,
    output logic                           resp_valid,
    input  logic                           resp_ready,
    output logic [31:0]                    resp_instr,
    output logic [ADDR_W-1:0]              resp_addr,
    output logic [1:0]                     resp_fault,
    input  logic                           flush,
    input  logic                           load_en,
    input  logic [$clog2(DEPTH_WORDS)-1:0] load_addr,
    input  logic [31:0]                    load_data
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [31:0]       mem [DEPTH_WORDS] = '{default: NOP_INSTR};
    logic [31:0]       q_instr [RESP_DEPTH];
    logic [ADDR_W-1:0] q_addr [RESP_DEPTH];
    logic [1:0]        q_fault [RESP_DEPTH];
    logic [PW-1:0]     wp, rp;
    logic [CW-1:0]     count;
    logic [1:0]        fault;
    logic              fire, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(RESP_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign fault      = {req_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS), |req_addr[1:0]};
    assign resp_valid = count != '0;
    assign pop        = resp_valid && resp_ready;
    // The synchronous array read lands directly in the FIFO slot, so nothing is ever
    // in flight across a clock edge and the pop credit alone gives full throughput.
    assign req_ready  = !rst && !load_en && !flush && (count - CW'(pop)) < CW'(RESP_DEPTH);
    assign fire       = req_valid && req_ready;
    assign resp_instr = resp_valid ? q_instr[rp] : '0;
    assign resp_addr  = resp_valid ? q_addr[rp] : '0;
    assign resp_fault = resp_valid ? q_fault[rp] : '0;

    // Program-load write port; contents survive reset
    always_ff @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
    end

    // Capture the fetched word (or the fill instruction on a fault) into the tail slot
    always_ff @(posedge clk) begin
        if (fire) begin
            q_instr[wp] <= fault != 2'b00 ? NOP_INSTR : mem[req_addr[AW+1:2]];
            q_addr[wp]  <= req_addr;
            q_fault[wp] <= fault;
        end
    end

    // FIFO pointers and occupancy; reset and flush discard everything queued
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (fire) wp <= nxt(wp);
            if (pop) rp <= nxt(rp);
            count <= count + CW'(fire) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: table-driven check of fetch, faults, backpressure, flush, load and reset
module tb_instr_fetch_mem;
    logic        clk = 0, rst = 1, req_valid = 0, resp_ready = 0, flush = 0, load_en = 0;
    logic [31:0] req_addr = 0, load_data = 0;
    logic [7:0]  load_addr = 0;
    logic        req_ready, resp_valid;
    logic [31:0] resp_instr, resp_addr;
    logic [1:0]  resp_fault;
    int          n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    instr_fetch_mem dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_instr(resp_instr),
        .resp_addr(resp_addr), .resp_fault(resp_fault), .flush(flush), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data)
    );

    typedef struct {
        logic        rv;
        logic [31:0] ra;
        logic        rr, fl, le;
        logic [7:0]  la;
        logic [31:0] ld;
        logic        er, ev;
        logic [31:0] ei, ea;
        logic [1:0]  ef;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] ra, input logic rr, input logic fl,
                       input logic le, input logic [7:0] la, input logic [31:0] ld,
                       input logic er, input logic ev, input logic [31:0] ei,
                       input logic [31:0] ea, input logic [1:0] ef);
        vq.push_back('{rv, ra, rr, fl, le, la, ld, er, ev, ei, ea, ef});
    endtask

    task automatic outs(input string tag, input logic er, input logic ev, input logic [31:0] ei,
                        input logic [31:0] ea, input logic [1:0] ef);
        chk({tag, " req_ready"}, 32'(req_ready), 32'(er));
        chk({tag, " resp_valid"}, 32'(resp_valid), 32'(ev));
        chk({tag, " resp_instr"}, resp_instr, ei);
        chk({tag, " resp_addr"}, resp_addr, ea);
        chk({tag, " resp_fault"}, 32'(resp_fault), 32'(ef));
    endtask

    task automatic step(input vec_t v, input string tag);
        @(posedge clk);
        #1;
        req_valid = v.rv; req_addr = v.ra; resp_ready = v.rr; flush = v.fl;
        load_en = v.le; load_addr = v.la; load_data = v.ld;
        #1;
        outs(tag, v.er, v.ev, v.ei, v.ea, v.ef);
    endtask

    initial begin
        // program load and streaming fetch
        add(0, 0, 1, 0, 1, 0, 32'h11111111, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 32'h22222222, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 2, 32'h33333333, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 3, 32'h44444444, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 4, 1, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0);
        add(1, 8, 1, 0, 0, 0, 0, 1, 1, 32'h22222222, 4, 0);
        add(1, 12, 1, 0, 0, 0, 0, 1, 1, 32'h33333333, 8, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h44444444, 12, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // faults: misaligned, out of range, both
        add(1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h13, 6, 2'b01);
        add(1, 32'h400, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 32'h401, 1, 0, 0, 0, 0, 1, 1, 32'h13, 32'h400, 2'b10);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h13, 32'h401, 2'b11);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // backpressure with a two-entry FIFO
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 4, 0, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0);
        add(1, 8, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, 0, 0);
        add(1, 8, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, 0, 0);
        add(1, 8, 1, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h22222222, 4, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h33333333, 8, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // flush with two queued and a request pending
        add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 4, 0, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0);
        add(1, 8, 0, 1, 0, 0, 0, 0, 1, 32'h11111111, 0, 0);
        add(1, 8, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h33333333, 8, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        // read after load
        add(1, 32'h14, 1, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        add(1, 32'h14, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'h14, 0);
        add(0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

        rst = 1; req_valid = 1; resp_ready = 1;
        @(posedge clk);
        #2;
        outs("reset", 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 0; req_valid = 0;
        #1;
        outs("after_reset", 1, 0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("v%0d", i));

        // reset with the FIFO full, then confirm the array kept its contents
        step('{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0}, "r0");
        step('{1, 4, 0, 0, 0, 0, 0, 1, 1, 32'h11111111, 0, 0}, "r1");
        step('{1, 8, 0, 0, 0, 0, 0, 0, 1, 32'h11111111, 0, 0}, "r2");
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        outs("rst_full", 0, 1, 32'h11111111, 0, 0);
        @(posedge clk);
        #1;
        rst = 0; req_valid = 0;
        #1;
        outs("rst_drop", 1, 0, 0, 0, 0);
        step('{1, 32'h14, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0}, "r3");
        step('{1, 32'h18, 1, 0, 0, 0, 0, 1, 1, 32'hDEADBEEF, 32'h14, 0}, "r4");
        step('{0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h13, 32'h18, 0}, "r5");
        step('{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0}, "r6");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
